// File: rtl/memory_pkg.sv
// Shared memory-side types: arbiter state/owner encodings and the registered
// bus request bundle driven toward the bridge.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    INST,
    DATA
  } arb_owner_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] wdata;
  } bus_req_t;

  localparam logic [2:0] SIZE_WORD = 3'd2;

  // Fetches are always full-word reads with the write fields cleared.
  function automatic bus_req_t inst_req(input logic [31:0] addr);
    bus_req_t r;
    r      = '0;
    r.addr = addr;
    r.size = SIZE_WORD;
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational winner selection: data by default, instruction when data is
// absent or the starvation limit has been reached; flushed fetches never win.
module arb_pick (
  input  logic ireq_valid,
  input  logic iflush,
  input  logic dreq_valid,
  input  logic starved,
  output logic grant_inst,
  output logic grant_data
);

  logic inst_live;

  always_comb begin
    inst_live  = ireq_valid && !iflush;
    grant_inst = inst_live && (!dreq_valid || starved);
    grant_data = dreq_valid && !grant_inst;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the uncached memory bus between fetch and memory stages: one
// registered transaction at a time, with bounded starvation of fetches.
module mem_bus_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ireq_valid,
  input  logic [31:0] ireq_addr,
  input  logic        iflush,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic        dreq_write,
  input  logic [31:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [3:0]  dreq_strobe,
  input  logic [31:0] dreq_data,
  output logic        dresp_data_ok,
  output logic [31:0] dresp_data,
  output logic        bus_valid,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [2:0]  bus_size,
  output logic [3:0]  bus_strobe,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_okay,
  input  logic [31:0] bus_rdata
);

  arb_state_t  state, state_nx;
  arb_owner_t  owner;
  logic        cancel;
  logic [3:0]  starve_cnt;
  bus_req_t    bus_q;
  logic [31:0] resp_q;
  logic        starved;
  logic        grant_inst, grant_data;
  logic        bus_done;

  assign starved = (starve_cnt == 4'(STARVE_LIMIT));

  arb_pick u_pick (
    .ireq_valid (ireq_valid),
    .iflush     (iflush),
    .dreq_valid (dreq_valid),
    .starved    (starved),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  always_comb begin
    state_nx      = state;
    bus_done      = 1'b0;
    bus_valid     = 1'b0;
    iresp_data_ok = 1'b0;
    dresp_data_ok = 1'b0;
    unique case (state)
      IDLE: if (grant_inst || grant_data) state_nx = REQ;
      REQ: begin
        bus_valid = 1'b1;
        if (bus_ready) begin
          bus_done = bus_okay;
          state_nx = bus_okay ? RESP : WAIT;
        end
      end
      WAIT: if (bus_okay) begin
        bus_done = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        // A flush arriving in the response cycle still kills the fetch pulse.
        iresp_data_ok = (owner == INST) && !cancel && !iflush;
        dresp_data_ok = (owner == DATA);
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= NONE;
      cancel     <= 1'b0;
      starve_cnt <= '0;
      bus_q      <= '0;
      resp_q     <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (grant_inst) begin
            owner      <= INST;
            bus_q      <= inst_req(ireq_addr);
            starve_cnt <= '0;
          end else if (grant_data) begin
            owner <= DATA;
            bus_q <= '{write: dreq_write, addr: dreq_addr, size: dreq_size,
                       strobe: dreq_strobe, wdata: dreq_data};
            if (ireq_valid && !iflush && starve_cnt != 4'hF)
              starve_cnt <= starve_cnt + 4'd1;
          end
          if (!ireq_valid) starve_cnt <= '0;
        end
        REQ, WAIT: begin
          if (owner == INST && iflush) cancel <= 1'b1;
          if (bus_done) resp_q <= bus_rdata;
        end
        RESP: begin
          owner  <= NONE;
          cancel <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus_write  = bus_q.write;
  assign bus_addr   = bus_q.addr;
  assign bus_size   = bus_q.size;
  assign bus_strobe = bus_q.strobe;
  assign bus_wdata  = bus_q.wdata;
  assign iresp_data = resp_q;
  assign dresp_data = resp_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written
// starvation and async-reset sequences, and a random run against a timeline model.
module tb_mem_bus_arbiter;
  import memory_pkg::*;

  localparam int unsigned LIMIT  = 4;
  localparam logic [31:0] IADDR  = 32'h0000_1000;
  localparam logic [31:0] DADDR  = 32'h8000_0010;
  localparam logic [3:0]  DSTRB  = 4'b0011;
  localparam logic [31:0] DWDATA = 32'h1234_5678;
  localparam logic [2:0]  DSIZE  = 3'd1;
  localparam logic [2:0]  ISIZE  = 3'd2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ireq_valid, iflush, iresp_data_ok;
  logic [31:0] ireq_addr, iresp_data;
  logic        dreq_valid, dreq_write, dresp_data_ok;
  logic [31:0] dreq_addr, dreq_data, dresp_data;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic        bus_valid, bus_write, bus_ready, bus_okay;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [2:0]  bus_size;
  logic [3:0]  bus_strobe;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .iflush(iflush),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_size(bus_size), .bus_strobe(bus_strobe), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_okay(bus_okay), .bus_rdata(bus_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    ireq_valid = 1'b0; ireq_addr = '0; iflush = 1'b0;
    dreq_valid = 1'b0; dreq_write = 1'b0; dreq_addr = '0;
    dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
    bus_ready = 1'b0; bus_okay = 1'b0; bus_rdata = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_bus_valid"},  32'(bus_valid), 32'd0);
    chk({tag, "_bus_write"},  32'(bus_write), 32'd0);
    chk({tag, "_bus_addr"},   bus_addr, 32'd0);
    chk({tag, "_bus_size"},   32'(bus_size), 32'd0);
    chk({tag, "_bus_strobe"}, 32'(bus_strobe), 32'd0);
    chk({tag, "_bus_wdata"},  bus_wdata, 32'd0);
    chk({tag, "_iresp_ok"},   32'(iresp_data_ok), 32'd0);
    chk({tag, "_iresp_data"}, iresp_data, 32'd0);
    chk({tag, "_dresp_ok"},   32'(dresp_data_ok), 32'd0);
    chk({tag, "_dresp_data"}, dresp_data, 32'd0);
  endtask

  // Leaves the bench at posedge+1 of the first post-reset cycle.
  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    chk("reset_starve", 32'(dut.starve_cnt), 32'd0);
    resetn = 1'b1;
  endtask

  typedef struct {
    bit          iv, ifl, dv, dw, rdy, ok;
    logic [31:0] rdata;
    bit          e_bv, e_inst, e_iok, e_dok, e_chk;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input bit iv, input bit ifl, input bit dv, input bit dw,
                              input bit rdy, input bit ok, input logic [31:0] rd,
                              input bit ebv, input bit einst, input bit eiok,
                              input bit edok, input bit echk, input logic [31:0] ed);
    vec_t r;
    r.iv = iv; r.ifl = ifl; r.dv = dv; r.dw = dw; r.rdy = rdy; r.ok = ok; r.rdata = rd;
    r.e_bv = ebv; r.e_inst = einst; r.e_iok = eiok; r.e_dok = edok;
    r.e_chk = echk; r.e_data = ed;
    return r;
  endfunction

  // Timeline reference model state for the random run.
  bit          m_txn, m_acc, m_done, m_canc, m_inst;
  int          m_issue, m_resp, m_streak;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic        m_write;
  logic [2:0]  m_size;
  logic [3:0]  m_strobe;
  bit          i_act, d_act, saw_iok, saw_dok, fl_last, br_pend;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        d_write;
  logic [2:0]  d_size;
  logic [3:0]  d_strobe;
  bit          e_bv, e_resp, e_iok, e_dok, iv_eff;
  int          d_left, guard, d_grants;
  bit          i_done;
  string       seq;

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    // cycle-by-cycle directed table, rows start at the first post-reset cycle
    vt.push_back(mk(0,0,1,0,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,0,1,0,32'h0,        1,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,0,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,0,0,1,32'hDEADBEEF, 0,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,0,0,0,32'h0,        0,0,0,1,1,32'hDEADBEEF));
    vt.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(1,0,1,0,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(1,0,1,0,1,1,32'h11111111, 1,0,0,0,0,32'h0));
    vt.push_back(mk(1,0,1,0,0,0,32'h0,        0,0,0,1,1,32'h11111111));
    vt.push_back(mk(1,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(1,0,0,0,1,1,32'hCAFEF00D, 1,1,0,0,0,32'h0));
    vt.push_back(mk(1,0,0,0,0,0,32'h0,        0,0,1,0,1,32'hCAFEF00D));
    vt.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(1,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(1,0,1,0,1,0,32'h0,        1,1,0,0,0,32'h0));
    vt.push_back(mk(1,1,1,0,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,0,0,1,32'h00000055, 0,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,0,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,0,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,0,1,1,32'h00000077, 1,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,0,0,0,32'h0,        0,0,0,1,1,32'h00000077));
    vt.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,1,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,1,1,1,32'h0,        1,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,1,0,0,32'h0,        0,0,0,1,0,32'h0));
    vt.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(1,1,0,0,0,0,32'h0,        0,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,0,0,0,1,32'hFFFFFFFF, 0,0,0,0,0,32'h0));
    vt.push_back(mk(0,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0));

    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      ireq_valid = vt[i].iv; iflush = vt[i].ifl; ireq_addr = IADDR;
      dreq_valid = vt[i].dv; dreq_write = vt[i].dw; dreq_addr = DADDR;
      dreq_size = DSIZE; dreq_strobe = DSTRB; dreq_data = DWDATA;
      bus_ready = vt[i].rdy; bus_okay = vt[i].ok; bus_rdata = vt[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_bus_valid", i), 32'(bus_valid), 32'(vt[i].e_bv));
      chk($sformatf("vec%0d_iresp_ok", i), 32'(iresp_data_ok), 32'(vt[i].e_iok));
      chk($sformatf("vec%0d_dresp_ok", i), 32'(dresp_data_ok), 32'(vt[i].e_dok));
      if (vt[i].e_bv) begin
        chk($sformatf("vec%0d_bus_addr", i), bus_addr, vt[i].e_inst ? IADDR : DADDR);
        chk($sformatf("vec%0d_bus_write", i), 32'(bus_write), vt[i].e_inst ? 32'd0 : 32'(vt[i].dw));
        chk($sformatf("vec%0d_bus_size", i), 32'(bus_size), vt[i].e_inst ? 32'(ISIZE) : 32'(DSIZE));
        chk($sformatf("vec%0d_bus_strobe", i), 32'(bus_strobe), vt[i].e_inst ? 32'd0 : 32'(DSTRB));
        chk($sformatf("vec%0d_bus_wdata", i), bus_wdata, vt[i].e_inst ? 32'd0 : DWDATA);
      end
      if (vt[i].e_chk) begin
        if (vt[i].e_iok) chk($sformatf("vec%0d_iresp_data", i), iresp_data, vt[i].e_data);
        else             chk($sformatf("vec%0d_dresp_data", i), dresp_data, vt[i].e_data);
      end
      @(posedge clk); #1;
    end

    // starvation: fetch held while five data requests arrive back to back
    do_reset();
    ireq_addr = IADDR; dreq_addr = DADDR; dreq_size = DSIZE;
    dreq_strobe = DSTRB; dreq_data = DWDATA;
    ireq_valid = 1'b1; dreq_valid = 1'b1;
    d_left = 5; i_done = 1'b0; guard = 0; d_grants = 0; seq = "";
    while ((d_left > 0 || !i_done) && guard < 200) begin
      bus_ready = bus_valid; bus_okay = bus_valid; bus_rdata = 32'(guard);
      if (bus_valid) begin
        if (bus_addr == IADDR) begin
          seq = {seq, "I"};
          chk("starve_cnt_after_inst", 32'(dut.starve_cnt), 32'd0);
        end else begin
          seq = {seq, "D"};
          d_grants++;
          if (d_grants == 4) chk("starve_cnt_at_limit", 32'(dut.starve_cnt), 32'(LIMIT));
        end
      end
      @(negedge clk);
      if (dresp_data_ok) d_left--;
      if (iresp_data_ok) i_done = 1'b1;
      @(posedge clk); #1;
      ireq_valid = !i_done;
      dreq_valid = (d_left > 0);
      guard++;
    end
    chk("starve_no_timeout", 32'(guard < 200), 32'd1);
    checks++;
    if (seq != "DDDDID") begin
      errors++;
      $display("FAIL starve_order actual=%s expected=DDDDID", seq);
    end

    // asynchronous reset while waiting for bus_okay
    do_reset();
    dreq_valid = 1'b1; dreq_addr = DADDR; dreq_size = DSIZE;
    @(posedge clk); #1;
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    chk("rst_in_wait", 32'(dut.state), 32'(WAIT));
    #2 resetn = 1'b0;
    #1;
    check_outputs_zero("rst_async");
    chk("rst_async_state", 32'(dut.state), 32'(IDLE));
    chk("rst_async_owner", 32'(dut.owner), 32'(NONE));
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_bus_valid", 32'(bus_valid), 32'd1);
    chk("rst_after_bus_addr", bus_addr, DADDR);
    bus_ready = 1'b1; bus_okay = 1'b1; bus_rdata = 32'hA5A5_5A5A;
    @(posedge clk); #1;
    bus_ready = 1'b0; bus_okay = 1'b0;
    @(negedge clk);
    chk("rst_after_dresp_ok", 32'(dresp_data_ok), 32'd1);
    chk("rst_after_dresp_data", dresp_data, 32'hA5A5_5A5A);
    @(posedge clk); #1;
    dreq_valid = 1'b0;

    // random run against a transaction timeline model
    do_reset();
    m_txn = 0; m_streak = 0; i_act = 0; d_act = 0;
    saw_iok = 0; saw_dok = 0; fl_last = 0; br_pend = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (saw_iok || fl_last) i_act = 1'b0;
      if (saw_dok) d_act = 1'b0;
      if (!i_act && $urandom_range(2) == 0) begin
        i_act = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_act && $urandom_range(2) == 0) begin
        d_act = 1'b1; d_write = 1'($urandom_range(1)); d_addr = $urandom;
        d_size = 3'($urandom_range(2)); d_strobe = 4'($urandom); d_wdata = $urandom;
      end
      ireq_valid = i_act; ireq_addr = i_addr;
      iflush = ($urandom_range(11) == 0);
      fl_last = iflush && i_act;
      dreq_valid = d_act; dreq_write = d_write; dreq_addr = d_addr;
      dreq_size = d_size; dreq_strobe = d_strobe; dreq_data = d_wdata;
      if (bus_valid) begin
        bus_ready = 1'($urandom_range(1));
        bus_okay  = bus_ready && ($urandom_range(2) == 0);
        br_pend   = bus_ready && !bus_okay;
      end else if (br_pend) begin
        bus_ready = 1'b0;
        bus_okay  = ($urandom_range(2) == 0);
        if (bus_okay) br_pend = 1'b0;
      end else begin
        bus_ready = 1'b0;
        bus_okay  = ($urandom_range(7) == 0);
      end
      bus_rdata = $urandom;

      @(negedge clk);
      e_bv   = m_txn && (cyc >= m_issue) && !m_acc;
      e_resp = m_txn && m_done && (cyc == m_resp);
      e_iok  = e_resp && m_inst && !m_canc && !iflush;
      e_dok  = e_resp && !m_inst;
      chk($sformatf("rnd%0d_bus_valid", cyc), 32'(bus_valid), 32'(e_bv));
      chk($sformatf("rnd%0d_iresp_ok", cyc), 32'(iresp_data_ok), 32'(e_iok));
      chk($sformatf("rnd%0d_dresp_ok", cyc), 32'(dresp_data_ok), 32'(e_dok));
      if (e_bv) begin
        chk($sformatf("rnd%0d_bus_addr", cyc), bus_addr, m_addr);
        chk($sformatf("rnd%0d_bus_write", cyc), 32'(bus_write), 32'(m_write));
        chk($sformatf("rnd%0d_bus_size", cyc), 32'(bus_size), 32'(m_size));
        chk($sformatf("rnd%0d_bus_strobe", cyc), 32'(bus_strobe), 32'(m_strobe));
        chk($sformatf("rnd%0d_bus_wdata", cyc), bus_wdata, m_wdata);
      end
      if (e_iok) chk($sformatf("rnd%0d_iresp_data", cyc), iresp_data, m_rdata);
      if (e_dok && !m_write) chk($sformatf("rnd%0d_dresp_data", cyc), dresp_data, m_rdata);

      if (m_txn) begin
        if (e_resp) m_txn = 1'b0;
        else begin
          if (m_inst && iflush) m_canc = 1'b1;
          if (!m_acc) begin
            if (bus_ready) begin
              m_acc = 1'b1;
              if (bus_okay) begin m_done = 1'b1; m_resp = cyc + 1; m_rdata = bus_rdata; end
            end
          end else if (!m_done && bus_okay) begin
            m_done = 1'b1; m_resp = cyc + 1; m_rdata = bus_rdata;
          end
        end
      end else begin
        iv_eff = ireq_valid && !iflush;
        if (iv_eff && (!dreq_valid || m_streak == int'(LIMIT))) begin
          m_txn = 1'b1; m_inst = 1'b1; m_streak = 0;
          m_addr = ireq_addr; m_write = 1'b0; m_size = ISIZE; m_strobe = '0; m_wdata = '0;
        end else if (dreq_valid) begin
          m_txn = 1'b1; m_inst = 1'b0;
          if (iv_eff && m_streak < 15) m_streak++;
          m_addr = dreq_addr; m_write = dreq_write; m_size = dreq_size;
          m_strobe = dreq_strobe; m_wdata = dreq_data;
        end
        if (!ireq_valid) m_streak = 0;
        if (m_txn) begin
          m_issue = cyc + 1; m_acc = 1'b0; m_done = 1'b0; m_canc = 1'b0; m_resp = -1;
        end
      end
      saw_iok = iresp_data_ok;
      saw_dok = dresp_data_ok;
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single uncached memory bus between the fetch stage (instruction reads) and the memory stage (data loads/stores), one transaction at a time. Sits between the pipeline request ports and the external bus bridge. Grants data over instruction with a bounded-starvation override, registers the winning request onto the bus, tracks the handshake, and returns a one-cycle response to the owner. An instruction transaction in flight can be cancelled by a fetch flush.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request waits; the next grant then goes to instruction (range 1..15).
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- ireq_valid  in  1  fetch read request; held until iresp_data_ok or flush.
- ireq_addr  in  32  fetch address, word-aligned.
- iflush  in  1  fetch redirect; cancels a pending or in-flight instruction request.
- iresp_data_ok  out  1  one-cycle pulse; iresp_data valid.
- iresp_data  out  32  instruction word.
- dreq_valid  in  1  data request; held stable until dresp_data_ok.
- dreq_write  in  1  1 = store, 0 = load.
- dreq_addr  in  32  data address.
- dreq_size  in  3  access size code as in the mem request struct.
- dreq_strobe  in  4  byte enables (stores).
- dreq_data  in  32  store data.
- dresp_data_ok  out  1  one-cycle pulse; load data valid / store complete.
- dresp_data  out  32  load data.
- bus_valid  out  1  request to bridge; held until bus_ready.
- bus_write, bus_addr, bus_size, bus_strobe, bus_wdata  out  1/32/3/4/32  registered request fields.
- bus_ready  in  1  bridge accepted request this cycle.
- bus_okay  in  1  transaction finished; bus_rdata valid this cycle.
- bus_rdata  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT, RESP; owner register (NONE/INST/DATA).
- IDLE: choose winner among valid requesters. Default: data wins. If ireq_valid, dreq_valid, and starve_cnt == STARVE_LIMIT, instruction wins. An instruction request with iflush high in the same cycle is not granted. On grant, latch the request fields into bus registers and go to REQ.
- starve_cnt: saturating counter. Increments on a data grant while ireq_valid && !iflush. Clears on an instruction grant, or on any IDLE cycle with ireq_valid low.
- REQ: bus_valid=1, fields stable.
  - bus_ready && bus_okay in the same cycle -> RESP.
  - bus_ready alone -> WAIT.
- WAIT: bus_valid=0; bus_okay -> RESP.
- RESP: owner's data_ok pulses for one cycle, with data taken from the resp_data register captured at bus_okay. Then go to IDLE.
- Cancel: iflush while owner=INST in REQ or WAIT sets the cancel flag. The bus transaction still completes; in RESP, iresp_data_ok is suppressed. iflush in RESP also suppresses the pulse. The cancel flag clears on entering IDLE.
- Stores: dresp_data_ok pulses at completion; dresp_data is don't-care.
- Write fields (bus_write, bus_strobe, bus_wdata) are 0 for instruction grants.

## Timing
- Reset values: state IDLE, owner NONE, cancel 0, starve_cnt 0. All outputs are 0, including bus fields and response data.
- Best-case latency: request at cycle 0 -> bus_valid at 1 -> bus_ready+bus_okay at 1 -> data_ok at 2.
- Typical: bus_ready at 1, bus_okay at 3 -> data_ok at 4.
- No back-to-back grant: after RESP the arbiter spends one IDLE cycle before the next bus_valid, so minimum issue interval is 3 cycles.
- Requesters must not change fields while valid and not yet acknowledged. The arbiter does not check this.
- bus_okay outside WAIT/REQ is ignored.
- Reset mid-transaction: immediate return to reset state. The bridge is reset by the same resetn.

## Structure
- memory_pkg gains:
  - arb_state_t enum (IDLE, REQ, WAIT, RESP)
  - arb_owner_t enum (NONE, INST, DATA)
  - a bus_req_t struct bundling write/addr/size/strobe/wdata
- One sub-module, arb_pick: combinational winner selection from ireq_valid, iflush, dreq_valid, and the starvation flag.
- The counter and FSM live in the top.

## Test plan
- Data read alone: dreq addr 0x8000_0010. Bus_ready at cycle 1, bus_okay with rdata 0xDEAD_BEEF at cycle 3 -> dresp_data_ok at cycle 4 with 0xDEAD_BEEF; iresp_data_ok stays 0.
- Contention: both valid at cycle 0 -> data is granted first (bus_addr = dreq_addr). Instruction is granted on the next IDLE.
- Starvation (STARVE_LIMIT=4): ireq held, five back-to-back data requests -> grants go D,D,D,D,I,D; starve_cnt returns to 0 after the I grant.
- Flush in WAIT: instruction granted, iflush pulsed in WAIT, bus_okay arrives -> no iresp_data_ok. The next pending data request is granted normally.
- Store with bus_ready+bus_okay in one cycle: strobe 4'b0011, data 0x1234_5678 -> bus fields match; dresp_data_ok 1 cycle after okay.
- Async reset asserted in WAIT -> all outputs 0 immediately, state IDLE; after release, a new request completes normally.
